// File: rtl/spi_dual_master.sv
`timescale 1ns/1ps
// spi_dual_master: SPI mode-0 (CPOL=0, CPHA=0) master driving two slave ports,
// each with its own active-low select and MISO return line.
// Optional build macro: SPI_MASTER_LOOPBACK_EN adds a loopback input that, when
// captured high with start, samples the internal mosi register instead of MISO.
module spi_dual_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              slave_sel,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              ss1,
    output logic              ss2,
    input  logic              miso1_in,
    input  logic              miso2_in
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t            state, next_state;
    logic [HW-1:0]     hcnt;
    logic [EW-1:0]     ecnt;
    logic              sel_q;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              half_last;
    logic              last_edge;
    logic              sel_next;
    logic              active_next;
    logic              sample;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic              lb_q;
`endif

    assign half_last = (hcnt == H_LAST);
    assign last_edge = (ecnt == E_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic plus look-ahead terms used to register the outputs
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = SETUP;
            SETUP: if (half_last) next_state = SHIFT;
            SHIFT: if (half_last && last_edge) next_state = HOLD;
            HOLD:  if (half_last) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        sel_next    = (state == IDLE) ? slave_sel : sel_q;
        active_next = (next_state == SETUP) || (next_state == SHIFT) || (next_state == HOLD);
    end

    // Rising-edge sample source
    always_comb begin
        sample = sel_q ? miso2_in : miso1_in;
`ifdef SPI_MASTER_LOOPBACK_EN
        if (lb_q) sample = mosi;
`endif
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss1      <= 1'b1;
            ss2      <= 1'b1;
            hcnt     <= '0;
            ecnt     <= '0;
            sel_q    <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
        end else begin
            busy <= active_next;
            done <= (next_state == DONE);
            ss1  <= ~(active_next & ~sel_next);
            ss2  <= ~(active_next & sel_next);
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    ecnt <= '0;
                    if (start) begin
                        sel_q    <= slave_sel;
                        tx_shift <= tx_data << 1;
                        mosi     <= tx_data[DATA_W-1];
                        rx_shift <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
                        lb_q     <= loopback;
`endif
                    end
                end
                SETUP, HOLD: begin
                    hcnt <= half_last ? '0 : hcnt + HW'(1);
                end
                SHIFT: begin
                    hcnt <= half_last ? '0 : hcnt + HW'(1);
                    if (half_last) begin
                        sclk <= ~sclk;
                        ecnt <= ecnt + EW'(1);
                        if (!sclk) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], sample};
                        end else if (!last_edge) begin
                            mosi     <= tx_shift[DATA_W-1];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                default: begin
                    hcnt <= '0;
                    ecnt <= '0;
                end
            endcase
            // rx_data and the idle mosi level are set on entry so they show in the done cycle
            if (next_state == DONE) begin
                mosi    <= 1'b0;
                rx_data <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_dual_master.sv
`timescale 1ns/1ps
// Directed bench for spi_dual_master: a CLK_DIV=4 instance and a CLK_DIV=1 instance
// share inputs except start; the bench plays the SPI slave from the initial block.
module tb_spi_dual_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_f;
    logic       slave_sel;
    logic [7:0] tx_data;
    logic       miso1, miso2;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback;
`endif

    logic       busy_a, done_a, sclk_a, mosi_a, ss1_a, ss2_a;
    logic [7:0] rx_a;
    logic       busy_f, done_f, sclk_f, mosi_f, ss1_f, ss2_f;
    logic [7:0] rx_f;

    logic       use_f;
    logic       m_busy, m_done, m_sclk, m_mosi, m_ss1, m_ss2;
    logic [7:0] m_rx;

    int n_chk  = 0;
    int n_fail = 0;

    // Free-running clock
    always #5 clk = ~clk;

    spi_dual_master #(.DATA_W(8), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start_a), .slave_sel(slave_sel), .tx_data(tx_data),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
        .ss1(ss1_a), .ss2(ss2_a), .miso1_in(miso1), .miso2_in(miso2)
    );

    spi_dual_master #(.DATA_W(8), .CLK_DIV(1)) dut_fast (
        .clk(clk), .rst(rst), .start(start_f), .slave_sel(slave_sel), .tx_data(tx_data),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .busy(busy_f), .done(done_f), .rx_data(rx_f), .sclk(sclk_f), .mosi(mosi_f),
        .ss1(ss1_f), .ss2(ss2_f), .miso1_in(miso1), .miso2_in(miso2)
    );

    // View of whichever instance is under test
    always_comb begin
        m_busy = use_f ? busy_f : busy_a;
        m_done = use_f ? done_f : done_a;
        m_sclk = use_f ? sclk_f : sclk_a;
        m_mosi = use_f ? mosi_f : mosi_a;
        m_ss1  = use_f ? ss1_f  : ss1_a;
        m_ss2  = use_f ? ss2_f  : ss2_a;
        m_rx   = use_f ? rx_f   : rx_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, m_busy, 0);
        check({tag, " done"}, m_done, 0);
        check({tag, " rx"},   m_rx,   0);
        check({tag, " sclk"}, m_sclk, 0);
        check({tag, " mosi"}, m_mosi, 0);
        check({tag, " ss1"},  m_ss1,  1);
        check({tag, " ss2"},  m_ss2,  1);
    endtask

    task automatic xfer(input string tag, input logic f, input logic sel,
                        input logic [7:0] tx, input logic [7:0] sw, input logic [7:0] exp_rx,
                        input logic other, input int lat, input logic stray, input logic lb);
        int   cyc, rises, falls, last_rise, per_bad, ss_bad, busy_bad, mosi_bad, extra;
        int   half;
        logic prev_sclk;
        half = f ? 1 : 4;
        rises = 0; falls = 0; last_rise = 0; per_bad = 0; ss_bad = 0; busy_bad = 0;
        mosi_bad = 0; extra = 0;
        use_f = f;
        @(negedge clk);
        slave_sel = sel;
        tx_data   = tx;
        if (sel) begin miso2 = sw[7]; miso1 = other; end
        else     begin miso1 = sw[7]; miso2 = other; end
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = lb;
`endif
        if (f) start_f = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_f = 1'b0;
        slave_sel = ~sel;
        tx_data   = ~tx;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = ~lb;
`endif
        check({tag, " first busy"}, m_busy, 1);
        check({tag, " first sel ss"}, sel ? m_ss2 : m_ss1, 0);
        check({tag, " first mosi"}, m_mosi, tx[7]);
        cyc = 1;
        prev_sclk = m_sclk;
        while (!m_done && cyc < 200) begin
            if (stray && cyc == 19) begin
                if (f) start_f = 1'b1; else start_a = 1'b1;
                tx_data = 8'hFF;
            end
            if (stray && cyc == 20) begin start_a = 1'b0; start_f = 1'b0; end
            if ((sel ? m_ss2 : m_ss1) !== 1'b0 || (sel ? m_ss1 : m_ss2) !== 1'b1) ss_bad++;
            if (m_busy !== 1'b1) busy_bad++;
            if (m_sclk && !prev_sclk) begin
                if (rises >= 8 || m_mosi !== tx[7-rises]) mosi_bad++;
                if (rises > 0 && cyc - last_rise != 2 * half) per_bad++;
                last_rise = cyc;
                rises++;
            end
            if (!m_sclk && prev_sclk) begin
                falls++;
                if (falls < 8) begin
                    if (sel) miso2 = sw[7-falls]; else miso1 = sw[7-falls];
                end
            end
            prev_sclk = m_sclk;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done seen"}, m_done, 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " rx_data"}, m_rx, exp_rx);
        check({tag, " busy at done"}, m_busy, 0);
        check({tag, " ss1 at done"}, m_ss1, 1);
        check({tag, " ss2 at done"}, m_ss2, 1);
        check({tag, " mosi at done"}, m_mosi, 0);
        check({tag, " rising edges"}, rises, 8);
        check({tag, " falling edges"}, falls, 8);
        check({tag, " sclk period errs"}, per_bad, 0);
        check({tag, " ss errs"}, ss_bad, 0);
        check({tag, " busy errs"}, busy_bad, 0);
        check({tag, " mosi errs"}, mosi_bad, 0);
        repeat (stray ? 90 : 3) begin
            @(negedge clk);
            if (m_done || m_busy) extra++;
        end
        check({tag, " quiet after done"}, extra, 0);
        check({tag, " rx held"}, m_rx, exp_rx);
    endtask

    initial begin
        int cyc, extra;
        rst = 1'b1; start_a = 1'b0; start_f = 1'b0; slave_sel = 1'b0;
        tx_data = 8'h00; miso1 = 1'b0; miso2 = 1'b0; use_f = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(negedge clk);
        use_f = 1'b0; #1 check_idle("reset slow");
        use_f = 1'b1; #1 check_idle("reset fast");
        rst = 1'b0;

        xfer("s1 A5", 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 1'b0, 73, 1'b0, 1'b0);
        xfer("s2 0F", 1'b0, 1'b1, 8'h0F, 8'hC3, 8'hC3, 1'b1, 73, 1'b0, 1'b0);
        xfer("stray", 1'b0, 1'b0, 8'h96, 8'h69, 8'h69, 1'b0, 73, 1'b1, 1'b0);

        // Reset in the middle of a transfer
        use_f = 1'b0;
        @(negedge clk);
        slave_sel = 1'b0; tx_data = 8'h33; miso1 = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 1;
        while (cyc < 29) begin @(negedge clk); cyc++; end
        check("midrst busy before", m_busy, 1);
        check("midrst ss1 before", m_ss1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst ss1", m_ss1, 1);
        check("midrst ss2", m_ss2, 1);
        check("midrst sclk", m_sclk, 0);
        check("midrst busy", m_busy, 0);
        check("midrst done", m_done, 0);
        check("midrst rx", m_rx, 0);
        rst = 1'b0;
        extra = 0;
        repeat (90) begin @(negedge clk); if (m_done || m_busy) extra++; end
        check("midrst no done", extra, 0);

        xfer("after rst", 1'b0, 1'b1, 8'h3C, 8'hA5, 8'hA5, 1'b0, 73, 1'b0, 1'b0);
        xfer("fast 81", 1'b1, 1'b0, 8'h81, 8'h7E, 8'h7E, 1'b0, 19, 1'b0, 1'b0);
`ifdef SPI_MASTER_LOOPBACK_EN
        xfer("loopback", 1'b0, 1'b0, 8'h5A, 8'h00, 8'h5A, 1'b0, 73, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
